seq_pattern_tx: RTL
===================

Name: seq_pattern_tx

Overview:
- Serial transmitter for the 10011 bit-sequence protocol: emits a programmable pattern MSB-first on a single-bit line, a configurable number of times, with optional idle gaps between frames.
- Sits on the transmit side of the sequence-detection path. Used as the stimulus source for the team's Moore sequence detectors and as a standalone frame-marker generator.

Parameters:
- PAT_WIDTH, 5, number of bits per frame (2..16).
- PATTERN, 5'b10011, frame bits; bit PAT_WIDTH-1 is sent first.
- CNT_WIDTH, 8, width of repeat_count and the internal frame counter.
- GAP_WIDTH, 4, width of gap_len and the internal gap counter.
- IDLE_BIT, 1'b0, dout level whenever no frame bit is driven.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- repeat_count  input  CNT_WIDTH  frames to send; latched with start.
- gap_len  input  GAP_WIDTH  idle cycles between frames; latched with start.
- abort  input  1  synchronous cancel of a burst in progress.
- dout  output  1  serial data, registered.
- dout_valid  output  1  high while dout carries a pattern bit.
- frame_start  output  1  one-cycle pulse coincident with the first bit of each frame.
- busy  output  1  high from the first SHIFT cycle through the last GAP or SHIFT cycle.
- done  output  1  one-cycle pulse after the final bit of a completed burst.

Behaviour:
- All outputs are registered. Reset (sampled at a clk edge) forces: state IDLE, dout=IDLE_BIT, dout_valid=0, frame_start=0, busy=0, done=0, all counters 0. Reset overrides start and abort in the same cycle.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - start=1 and repeat_count!=0 latch repeat_count and gap_len, and go to SHIFT with bit_idx=0.
  - start with repeat_count==0 is ignored: no state change, no done pulse.
- Start-to-data latency is 1 cycle. If start is sampled at the edge ending cycle n, the first bit is on dout with dout_valid=1, frame_start=1, busy=1 during cycle n+1.
- SHIFT:
  - Each cycle drives dout=PATTERN[PAT_WIDTH-1-bit_idx] and dout_valid=1, then increments bit_idx.
  - A frame occupies exactly PAT_WIDTH consecutive cycles.
- After the last bit of a frame:
  - Frames remain and gap_len!=0: go to GAP for exactly gap_len cycles, with dout=IDLE_BIT and dout_valid=0.
  - Frames remain and gap_len==0: the next frame starts on the very next cycle, back-to-back with no idle bit.
  - No frames remain: go to DONE.
- GAP: at expiry, re-enter SHIFT with bit_idx=0; frame_start pulses with that first bit. busy stays 1 throughout GAP.
- DONE: lasts one cycle with done=1, busy=0, dout=IDLE_BIT, dout_valid=0, then IDLE. A start sampled in DONE is ignored.
- Burst length in cycles: repeat_count*PAT_WIDTH + (repeat_count-1)*gap_len.
- start while busy is ignored. Latched repeat_count and gap_len are immune to input changes mid-burst.
- abort=1 in SHIFT or GAP:
  - Next cycle is IDLE with dout=IDLE_BIT, dout_valid=0, busy=0.
  - No done pulse; a partial frame is truncated.
  - abort in IDLE or DONE has no effect.
- Counters never wrap: the frame counter decrements from the latched value to 0; max burst is 2^CNT_WIDTH-1 frames.

Decomposition:
- Shared package seq_pkg holds:
  - state encodings (IDLE, SHIFT, GAP, DONE as 2-bit localparams);
  - default PATTERN 5'b10011 and PAT_WIDTH 5, shared with the detectors;
  - the IDLE_BIT default.
- No sub-module is needed: a single FSM plus a bit index, frame counter and gap counter.

Test Plan:
- Reset, then start=1 with repeat_count=1 and gap_len=0 -> cycles 1..5 after start give dout=1,0,0,1,1 with dout_valid=1 and frame_start only in cycle 1. done=1 in cycle 6; busy=0 from cycle 6.
- repeat_count=3, gap_len=2 -> three frames of 10011, each separated by 2 cycles of dout=0 with dout_valid=0. frame_start in cycles 1, 8 and 15; done in cycle 20.
- repeat_count=2, gap_len=0 -> 10 consecutive valid bits 1001110011. frame_start in cycles 1 and 6; done in cycle 11.
- abort asserted in the 3rd bit of frame 2 (repeat_count=4, gap_len=1) -> IDLE next cycle, dout_valid=0, busy=0, no done pulse. A fresh start is then accepted normally.
- start pulsed while busy, and start with repeat_count=0 from IDLE -> both ignored: the bit stream, counts and done timing are unchanged; no output activity for the zero-count start.
- reset asserted mid-burst in the same cycle as start -> all outputs are at reset values on the next cycle, with no data emitted.

Source files
------------

// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the 10011 sequence path: transmitter state encoding,
// the default frame pattern and width (shared with the Moore detectors) and
// the default idle line level.
// -----------------------------------------------------------------------------
package seq_pkg;

   // Default frame: sent MSB-first, so the line carries 1,0,0,1,1.
   localparam int             SEQ_PAT_WIDTH = 5;
   localparam logic [4:0]     SEQ_PATTERN   = 5'b10011;

   // Line level whenever no pattern bit is being driven.
   localparam logic           SEQ_IDLE_BIT  = 1'b0;

   // Transmitter states, 2-bit encoded.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2,
      ST_DONE  = 2'd3
   } tx_state_e;

endpackage

// File: rtl/seq_pattern_tx.sv
// -----------------------------------------------------------------------------
// seq_pattern_tx
// Serial transmitter that emits PATTERN MSB-first, repeat_count times, with
// gap_len idle cycles between frames. All outputs are registered; the first
// bit appears on the cycle after start is sampled.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high reset
//   start        in   burst request, honoured only in IDLE with repeat_count!=0
//   repeat_count in   frames per burst, latched with start
//   gap_len      in   idle cycles between frames, latched with start
//   abort        in   cancels a burst in SHIFT or GAP, no done pulse
//   dout         out  serial data
//   dout_valid   out  dout carries a pattern bit
//   frame_start  out  pulse with the first bit of every frame
//   busy         out  high throughout SHIFT and GAP
//   done         out  one-cycle pulse after the final bit of a completed burst
// -----------------------------------------------------------------------------
module seq_pattern_tx
   import seq_pkg::*;
#(
   parameter int                   PAT_WIDTH = SEQ_PAT_WIDTH,
   parameter logic [PAT_WIDTH-1:0] PATTERN   = PAT_WIDTH'(SEQ_PATTERN),
   parameter int                   CNT_WIDTH = 8,
   parameter int                   GAP_WIDTH = 4,
   parameter logic                 IDLE_BIT  = SEQ_IDLE_BIT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [CNT_WIDTH-1:0] repeat_count,
   input  logic [GAP_WIDTH-1:0] gap_len,
   input  logic                 abort,
   output logic                 dout,
   output logic                 dout_valid,
   output logic                 frame_start,
   output logic                 busy,
   output logic                 done
);

   localparam int IDX_W = $clog2(PAT_WIDTH);

   localparam logic [IDX_W-1:0]     IDX_ZERO = {IDX_W{1'b0}};
   localparam logic [IDX_W-1:0]     IDX_ONE  = IDX_W'(1'b1);
   localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(PAT_WIDTH - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1'b1);
   localparam logic [GAP_WIDTH-1:0] GAP_ZERO = {GAP_WIDTH{1'b0}};
   localparam logic [GAP_WIDTH-1:0] GAP_ONE  = GAP_WIDTH'(1'b1);

   tx_state_e              state_r,     state_s;
   logic [IDX_W-1:0]       bit_idx_r,   bit_idx_s;
   // Frames still to send, including the one in flight.
   logic [CNT_WIDTH-1:0]   frame_cnt_r, frame_cnt_s;
   // Gap cycles still to spend, including the current one.
   logic [GAP_WIDTH-1:0]   gap_cnt_r,   gap_cnt_s;
   logic [GAP_WIDTH-1:0]   gap_len_r,   gap_len_s;

   logic [PAT_WIDTH-1:0]   pat_shift_s;
   logic                   dout_s;
   logic                   dout_valid_s;
   logic                   frame_start_s;
   logic                   busy_s;
   logic                   done_s;

   logic                   dout_r;
   logic                   dout_valid_r;
   logic                   frame_start_r;
   logic                   busy_r;
   logic                   done_r;

   // Next-state and counter logic.
   always_comb begin
      state_s     = state_r;
      bit_idx_s   = bit_idx_r;
      frame_cnt_s = frame_cnt_r;
      gap_cnt_s   = gap_cnt_r;
      gap_len_s   = gap_len_r;

      case (state_r)
         ST_IDLE: begin
            // A zero-frame request is dropped silently.
            if (start && (repeat_count != CNT_ZERO)) begin
               state_s     = ST_SHIFT;
               bit_idx_s   = IDX_ZERO;
               frame_cnt_s = repeat_count;
               gap_len_s   = gap_len;
               gap_cnt_s   = GAP_ZERO;
            end else begin
               state_s = ST_IDLE;
            end
         end

         ST_SHIFT: begin
            if (abort) begin
               state_s     = ST_IDLE;
               bit_idx_s   = IDX_ZERO;
               frame_cnt_s = CNT_ZERO;
               gap_cnt_s   = GAP_ZERO;
            end else if (bit_idx_r == IDX_LAST) begin
               frame_cnt_s = frame_cnt_r - CNT_ONE;
               bit_idx_s   = IDX_ZERO;
               if (frame_cnt_r == CNT_ONE) begin
                  state_s = ST_DONE;
               end else if (gap_len_r != GAP_ZERO) begin
                  state_s   = ST_GAP;
                  gap_cnt_s = gap_len_r;
               end else begin
                  // Back-to-back frames: restart the index without a gap.
                  state_s = ST_SHIFT;
               end
            end else begin
               bit_idx_s = bit_idx_r + IDX_ONE;
            end
         end

         ST_GAP: begin
            if (abort) begin
               state_s     = ST_IDLE;
               bit_idx_s   = IDX_ZERO;
               frame_cnt_s = CNT_ZERO;
               gap_cnt_s   = GAP_ZERO;
            end else if (gap_cnt_r == GAP_ONE) begin
               state_s   = ST_SHIFT;
               bit_idx_s = IDX_ZERO;
               gap_cnt_s = GAP_ZERO;
            end else begin
               gap_cnt_s = gap_cnt_r - GAP_ONE;
            end
         end

         ST_DONE: begin
            state_s = ST_IDLE;
         end

         default: begin
            state_s     = ST_IDLE;
            bit_idx_s   = IDX_ZERO;
            frame_cnt_s = CNT_ZERO;
            gap_cnt_s   = GAP_ZERO;
            gap_len_s   = GAP_ZERO;
         end
      endcase
   end

   // Output values for the upcoming cycle, derived from the next state so
   // that the registered outputs line up with the state they describe.
   always_comb begin
      pat_shift_s   = PATTERN << bit_idx_s;
      dout_s        = IDLE_BIT;
      dout_valid_s  = 1'b0;
      frame_start_s = 1'b0;
      busy_s        = 1'b0;
      done_s        = 1'b0;

      case (state_s)
         ST_SHIFT: begin
            dout_s        = pat_shift_s[PAT_WIDTH-1];
            dout_valid_s  = 1'b1;
            frame_start_s = (bit_idx_s == IDX_ZERO);
            busy_s        = 1'b1;
         end
         ST_GAP: begin
            busy_s = 1'b1;
         end
         ST_DONE: begin
            done_s = 1'b1;
         end
         default: begin
            busy_s = 1'b0;
         end
      endcase
   end

   // State, counters and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= ST_IDLE;
         bit_idx_r     <= IDX_ZERO;
         frame_cnt_r   <= CNT_ZERO;
         gap_cnt_r     <= GAP_ZERO;
         gap_len_r     <= GAP_ZERO;
         dout_r        <= IDLE_BIT;
         dout_valid_r  <= 1'b0;
         frame_start_r <= 1'b0;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
      end else begin
         state_r       <= state_s;
         bit_idx_r     <= bit_idx_s;
         frame_cnt_r   <= frame_cnt_s;
         gap_cnt_r     <= gap_cnt_s;
         gap_len_r     <= gap_len_s;
         dout_r        <= dout_s;
         dout_valid_r  <= dout_valid_s;
         frame_start_r <= frame_start_s;
         busy_r        <= busy_s;
         done_r        <= done_s;
      end
   end

   assign dout        = dout_r;
   assign dout_valid  = dout_valid_r;
   assign frame_start = frame_start_r;
   assign busy        = busy_r;
   assign done        = done_r;

endmodule
